// File: rtl/cpu_intc.sv
// cpu_intc: fixed-priority memory-mapped interrupt controller with EOI; define CPU_INTC_SYNC_EN for a 2-flop irq_src synchronizer
module cpu_intc #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        bus_address,
  input  logic [31:0]        bus_wdata,
  input  logic [3:0]         bus_control,
  output logic [31:0]        bus_rdata,
  output logic               bus_sel,
  output logic               interrupt,
  input  logic               interrupt_grant
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_n;
  logic [NUM_SRC-1:0] src, src_d, pending, enable, cand, pend_set, w1c, req_oh;
  logic [4:0] req_id, act_id, win_id;
  logic in_svc, rd, wr, eoi, take;
  logic [31:0] off;
  logic unused_ok;
  assign off       = bus_address - BASE_ADDR;
  assign bus_sel   = off[31:4] == 28'd0 && !reset;
  assign rd        = bus_sel && bus_control == 4'b0001;
  assign wr        = bus_sel && bus_control == 4'b0010;
  assign eoi       = wr && off[3:2] == 2'd3;
  assign w1c       = (wr && off[3:2] == 2'd0) ? bus_wdata[NUM_SRC-1:0] : '0;
  assign cand      = pending & enable;
  assign req_oh    = NUM_SRC'(1) << req_id;
  assign take      = state == REQ && interrupt_grant;
  assign pend_set  = src & ~src_d;
  assign interrupt = state == REQ;
  assign unused_ok = ^{off[1:0], bus_wdata};
  assign bus_rdata = !rd ? '0 :
                     off[3:2] == 2'd0 ? 32'(pending) :
                     off[3:2] == 2'd1 ? 32'(enable) :
                     off[3:2] == 2'd2 ? {in_svc, 26'd0, act_id} : '0;
`ifdef CPU_INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;
  assign src = sync2;
  // two-flop synchronizer for asynchronous peripheral lines
  always_ff @(posedge clk or posedge reset)
    if (reset) {sync1, sync2} <= '0;
    else {sync1, sync2} <= {irq_src, sync1};
`else
  assign src = irq_src;
`endif
  // lowest-index pending and enabled source wins
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (cand[i]) win_id = 5'(i);
  end
  // request/service sequencing; the held req_id is dropped once it stops being a candidate
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (|cand ? REQ : IDLE) :
              state == REQ  ? (interrupt_grant ? SERVICE : (|(cand & req_oh)) ? REQ : IDLE) :
              state == SERVICE ? (eoi ? IDLE : SERVICE) : IDLE;
  end
  // register file, edge history and service bookkeeping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      src_d   <= '0;
      pending <= '0;
      enable  <= '0;
      req_id  <= '0;
      act_id  <= '0;
      in_svc  <= 1'b0;
    end else begin
      state   <= state_n;
      src_d   <= src;
      pending <= (pending & ~w1c & ~(take ? req_oh : '0)) | pend_set;
      if (wr && off[3:2] == 2'd1) enable <= bus_wdata[NUM_SRC-1:0];
      if (state == IDLE) req_id <= win_id;
      if (take) {in_svc, act_id} <= {1'b1, req_id};
      else if (state == SERVICE && eoi) in_svc <= 1'b0;
    end
endmodule
